// File: rtl/mux_defs_pkg.sv
// Shared definitions for the 8:1 serial mux link (mux and demux sides).
package mux_defs_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int SEL_W_DEF = 3;
  localparam int LAST_SEL  = WIDTH_DEF - 1;

  // Select index of the final position for a given word width.
  function automatic int last_sel(input int width);
    return width - 1;
  endfunction
endpackage

// File: rtl/demux_deserializer_sel_counter.sv
// Mod-WIDTH select counter with sync clear, enable and terminal-count flag.
module sel_counter
  import mux_defs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             en,
  output logic [SEL_W-1:0] cnt,
  output logic             tc
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(last_sel(WIDTH));

  assign tc = en && (cnt == LAST);

  // A sync with an enabled bit places that bit at index 0, so count resumes at 1.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (sync) cnt <= en ? SEL_W'(1) : '0;
    else if (en)   cnt <= cnt + SEL_W'(1);
  end
endmodule

// File: rtl/demux_deserializer.sv
// Receive side of the 8:1 serial mux link: rebuilds LSB-first words and hands them off.
module demux_deserializer
  import mux_defs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             sync,
  output logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] o,
  output logic             o_valid,
  input  logic             out_ready,
  output logic             overrun
);
  generate
    if (WIDTH < 2 || (1 << SEL_W) != WIDTH) begin : g_bad_params
      $error("demux_deserializer: WIDTH must be 2**SEL_W and >= 2");
    end
  endgenerate

  logic [SEL_W-1:0] cnt;
  logic             tc;
  logic             done;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] acc;

  sel_counter #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .sync (sync),
    .en   (in_valid),
    .cnt  (cnt),
    .tc   (tc)
  );

  assign s    = cnt;
  // Sync outranks the terminal count: the bit restarts a frame instead of closing one.
  assign done = tc && !sync;
  assign idx  = sync ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (rst)           acc      <= '0;
    else if (in_valid) acc[idx] <= in_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o       <= '0;
      o_valid <= 1'b0;
      overrun <= 1'b0;
    end else if (done) begin
      o       <= {in_bit, acc[WIDTH-2:0]};
      o_valid <= 1'b1;
      if (o_valid && !out_ready) overrun <= 1'b1;
    end else if (o_valid && out_ready) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_demux_deserializer.sv
// Directed-vector bench for demux_deserializer with hand-computed expectations.
module tb_demux_deserializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       sync = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] s;
  logic [7:0] o;
  logic       o_valid;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  demux_deserializer #(.WIDTH(8), .SEL_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .sync      (sync),
    .s         (s),
    .o         (o),
    .o_valid   (o_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle past the rising edge.
  task automatic step(input logic iv, input logic b, input logic sy, input logic rdy);
    @(negedge clk);
    in_valid  = iv;
    in_bit    = b;
    sync      = sy;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; sync = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0, rdy);
  endtask

  initial begin
    logic [7:0] w4d;
    w4d = 8'h4D;

    // Reset state
    do_reset();
    chk("rst_s", s, 0);
    chk("rst_o", o, 0);
    chk("rst_ov", o_valid, 0);
    chk("rst_overrun", overrun, 0);

    // Continuous word 0x4D with out_ready=1
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_s%0d", i), s, i);
      chk($sformatf("t1_nv%0d", i), o_valid, 0);
      step(1'b1, w4d[i], 1'b0, 1'b1);
    end
    chk("t1_o", o, 8'h4D);
    chk("t1_ov", o_valid, 1);
    chk("t1_s_wrap", s, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_ov_1cyc", o_valid, 0);
    chk("t1_o_hold", o, 8'h4D);
    chk("t1_overrun", overrun, 0);

    // Same stream with a 3-cycle gap after bit 4
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, w4d[i], 1'b0, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk($sformatf("t2_gap_s%0d", g), s, 5);
      chk($sformatf("t2_gap_nv%0d", g), o_valid, 0);
    end
    for (int i = 5; i < 8; i++) step(1'b1, w4d[i], 1'b0, 1'b1);
    chk("t2_o", o, 8'h4D);
    chk("t2_ov", o_valid, 1);

    // Back-to-back words without consumption -> overrun
    do_reset();
    send_word(8'hA5, 1'b0);
    chk("t3_o1", o, 8'hA5);
    chk("t3_ov1", o_valid, 1);
    chk("t3_overrun1", overrun, 0);
    send_word(8'h3C, 1'b0);
    chk("t3_o2", o, 8'h3C);
    chk("t3_ov2", o_valid, 1);
    chk("t3_overrun2", overrun, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ov_clr", o_valid, 0);
    chk("t3_overrun_sticky", overrun, 1);
    chk("t3_o_hold", o, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ready_idle", o_valid, 0);

    // Sync with a bit mid-word discards the partial word
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_s5", s, 5);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_s_sync", s, 1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_o", o, 8'h01);
    chk("t4_ov", o_valid, 1);
    chk("t4_overrun", overrun, 0);

    // Completion on the same edge as a handshake: no overrun
    for (int i = 0; i < 7; i++) step(1'b1, w4d[i], 1'b0, 1'b0);
    chk("t5_pre_ov", o_valid, 1);
    chk("t5_pre_o", o, 8'h01);
    step(1'b1, w4d[7], 1'b0, 1'b1);
    chk("t5_o", o, 8'h4D);
    chk("t5_ov", o_valid, 1);
    chk("t5_overrun", overrun, 0);

    // Sync at the last position wins: no word completes
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_s7", s, 7);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t6_s_sync", s, 1);
    chk("t6_no_word", o_valid, 0);
    chk("t6_o", o, 0);

    // Reset mid-word with a valid word pending
    do_reset();
    send_word(8'hFF, 1'b0);
    chk("t7_o_ff", o, 8'hFF);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t7_s6", s, 6);
    do_reset();
    chk("t7_rst_s", s, 0);
    chk("t7_rst_o", o, 0);
    chk("t7_rst_ov", o_valid, 0);
    chk("t7_rst_overrun", overrun, 0);
    send_word(8'h3C, 1'b0);
    chk("t7_o", o, 8'h3C);
    chk("t7_ov", o_valid, 1);
    chk("t7_overrun", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
